// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame defaults and the
// parity helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    // Widest data word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int UART_PAR_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity bit the transmitter appends: mode 1 = even (^data), mode 0 = odd (~^data).
    function automatic logic uart_parity(input logic mode, input logic [UART_PAR_W-1:0] data);
        logic par;
        if (mode) begin
            par = ^data;
        end else begin
            par = ~^data;
        end
        return par;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Double-register the asynchronous input to settle metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / DATA_BITS data (LSB first) / parity / stop, oversampled
// by baud_tick_rx. Delivers one frame at a time with parity, framing and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_d_in,
    input  logic                 baud_tick_rx,
    input  logic                 p_sel,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_d_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // Tick index of the mid-bit sample in START, and of the full-bit sample elsewhere.
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    logic                  w_rx_sync;

    uart_state_e           r_state;
    uart_state_e           w_state_nxt;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [TICK_W-1:0]     w_tick_cnt_nxt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [BIT_W-1:0]      w_bit_cnt_nxt;
    // Set when a stop bit was sampled low (break); blocks new starts until the line goes high.
    logic                  r_wait_high;
    logic                  w_wait_high_nxt;

    logic                  w_shift_en;
    logic                  w_par_en;
    logic                  w_frame_done;

    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bit;
    logic [UART_PAR_W-1:0] w_par_data;
    logic                  w_par_err;
    logic                  w_frm_err;

    logic [DATA_BITS-1:0]  r_rx_d_out;
    logic                  r_rx_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun_err;

    uart_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx_d_in),
        .o_sync  (w_rx_sync)
    );

    // FSM state, tick/bit counters and break-wait flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_wait_high <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_wait_high <= w_wait_high_nxt;
        end
    end

    // Next-state, counter updates and per-bit sample strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_wait_high_nxt = r_wait_high;
        w_shift_en      = 1'b0;
        w_par_en        = 1'b0;
        w_frame_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tick_cnt_nxt = '0;
                w_bit_cnt_nxt  = '0;
                if (w_rx_sync) begin
                    w_wait_high_nxt = 1'b0;
                end else if (!r_wait_high) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick_rx) begin
                    if (r_tick_cnt == TICK_HALF) begin
                        w_tick_cnt_nxt = '0;
                        // A high mid-bit sample means the low level was a glitch.
                        if (w_rx_sync) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TICK_ONE;
                    end
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_DATA: begin
                if (baud_tick_rx) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_shift_en     = 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = ST_PARITY;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TICK_ONE;
                    end
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_PARITY: begin
                if (baud_tick_rx) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_par_en       = 1'b1;
                        w_state_nxt    = ST_STOP;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TICK_ONE;
                    end
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_STOP: begin
                if (baud_tick_rx) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt_nxt  = '0;
                        w_frame_done    = 1'b1;
                        w_state_nxt     = ST_IDLE;
                        w_wait_high_nxt = ~w_rx_sync;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TICK_ONE;
                    end
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_tick_cnt_nxt = '0;
                w_bit_cnt_nxt  = '0;
            end
        endcase
    end

    // Data shift register (LSB arrives first, enters at the top) and parity sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_par_bit <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {w_rx_sync, r_shift[DATA_BITS-1:1]};
            end else begin
                r_shift <= r_shift;
            end
            if (w_par_en) begin
                r_par_bit <= w_rx_sync;
            end else begin
                r_par_bit <= r_par_bit;
            end
        end
    end

    // Error terms evaluated at the stop-bit sample.
    always_comb begin
        w_par_data                  = '0;
        w_par_data[DATA_BITS-1:0]   = r_shift;
        w_par_err                   = (r_par_bit != uart_parity(p_sel, w_par_data));
        w_frm_err                   = ~w_rx_sync;
    end

    // Output holding registers: load on completion, discard on overrun, clear on read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_d_out    <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (w_frame_done) begin
            if (!r_rx_valid || rx_read) begin
                r_rx_d_out    <= r_shift;
                r_parity_err  <= w_par_err;
                r_frame_err   <= w_frm_err;
                r_rx_valid    <= 1'b1;
                r_overrun_err <= 1'b0;
            end else begin
                r_overrun_err <= 1'b1;
            end
        end else if (rx_read) begin
            r_rx_valid    <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_rx_valid    <= r_rx_valid;
            r_overrun_err <= r_overrun_err;
        end
    end

    assign rx_d_out    = r_rx_d_out;
    assign rx_valid    = r_rx_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of baud_tick_rx pulses per bit period; legal values are even and at least 8.
REQ-002 Parameter DATA_BITS, default 8: number of data bits per frame.
REQ-003 clk  input  1  the single clock; all flops are on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_d_in  input  1  serial line, asynchronous to clk, idles high.
REQ-006 baud_tick_rx  input  1  one-clk-wide strobe at OVERSAMPLE times the bit rate.
REQ-007 p_sel  input  1  parity mode: 0 = odd (expected parity bit = ~^data), 1 = even (expected parity bit = ^data); held stable for the whole frame.
REQ-008 rx_read  input  1  consumer acknowledge; clears rx_valid.
REQ-009 rx_d_out  output  DATA_BITS  last accepted byte.
REQ-010 rx_valid  output  1  rx_d_out and its error flags hold an unread frame.
REQ-011 parity_err  output  1  parity mismatch on the frame in rx_d_out.
REQ-012 frame_err  output  1  stop bit sampled 0 on the frame in rx_d_out.
REQ-013 overrun_err  output  1  sticky flag: a frame completed while rx_valid was high.

Function
REQ-014 Frame format: start bit 0, DATA_BITS data bits LSB first, one parity bit, one stop bit 1; this is the same frame the team's transmitter sends.
REQ-015 rx_d_in passes through a 2-flop synchronizer before any other use; all sampling uses the synchronized value.
REQ-016 State machine states and transitions:
- IDLE -> START when the synchronized line is 0; the tick counter clears on entry to START.
- START: samples on the (OVERSAMPLE/2)-th tick (mid-bit); goes to DATA if the sample is 0, otherwise back to IDLE (false start, no flags change).
- DATA: samples every OVERSAMPLE ticks and shifts the sample into bit [DATA_BITS-1]; goes to PARITY after DATA_BITS samples.
- PARITY: samples after OVERSAMPLE ticks, then goes to STOP.
- STOP: samples after OVERSAMPLE ticks, then returns to IDLE.
REQ-017 The tick counter advances only on baud_tick_rx and is width clog2(OVERSAMPLE); the bit counter is width clog2(DATA_BITS+1).
REQ-018 On the stop sample when rx_valid is 0, in the next clk cycle:
- rx_d_out loads the shifted byte;
- parity_err loads (sampled parity != expected parity);
- frame_err loads (stop sample == 0);
- rx_valid is set.
REQ-019 A frame is delivered even when parity_err or frame_err is set.
REQ-020 On the stop sample when rx_valid is 1 (and rx_read is not asserted that cycle):
- the new frame is discarded;
- rx_d_out, parity_err and frame_err are unchanged;
- overrun_err is set.
REQ-021 rx_read clears rx_valid and overrun_err on the next clk cycle.
REQ-022 If rx_read and a frame completion occur in the same cycle, the new frame loads, rx_valid stays 1 and overrun_err is not set.
REQ-023 Break condition (line held at 0 through the stop bit) produces one frame with rx_d_out = 0 and frame_err = 1; the FSM then waits in IDLE for the line to return high before accepting a new start.
REQ-024 Latency: rx_valid rises 1 clk after the stop-bit sample tick.

Reset
REQ-025 Asserting rst at any time, including mid-frame, forces within the same cycle:
- state = IDLE;
- rx_d_out = 0;
- rx_valid, parity_err, frame_err, overrun_err = 0;
- counters = 0;
- synchronizer flops = 1.
REQ-026 A partially received frame is discarded on reset; reception resumes at the first start bit detected after rst deasserts.

Structure
REQ-027 Package uart_pkg holds:
- the state enumeration;
- the DATA_BITS and OVERSAMPLE defaults;
- a shared parity function (mode, data) -> bit, used by both this block and the transmitter.
REQ-028 The 2-flop input synchronizer is sub-module uart_sync (reset value 1); all other logic stays in uart_rx.

Verification
REQ-029 p_sel=1, send 0xA5 with parity 0, stop 1 -> rx_d_out=0xA5, rx_valid=1, parity_err=0, frame_err=0; rx_read clears rx_valid.
REQ-030 p_sel=0, send 0x3C with parity 0 (expected 1) -> rx_d_out=0x3C, parity_err=1, frame_err=0.
REQ-031 Send 0x55 with stop bit 0 -> frame_err=1; line held 0 for 12 bit times -> exactly one frame with rx_d_out=0x00, frame_err=1.
REQ-032 Low glitch lasting 4 ticks (OVERSAMPLE=16) -> FSM returns to IDLE, rx_valid stays 0; a following valid 0x81 frame is received correctly.
REQ-033 Send 0x11 then 0x22 without rx_read -> rx_d_out=0x11, overrun_err=1; rx_read clears both flags.
REQ-034 Assert rst during data bit 4 of a frame, release it, then send 0xF0 -> only 0xF0 is delivered, with no error flags.
